// File: rtl/lif_pkg.sv
// Shared constants and helpers for the leaky integrate-and-fire neuron chain.
//   DEF_*     : default parameter values for the chain and its cells
//   sat_add   : unsigned add clipped to the all-ones value of a w-bit result
package lif_pkg;

    localparam int unsigned DEF_NUM_NEURONS = 3;
    localparam int unsigned DEF_W           = 8;
    localparam int unsigned DEF_LEAK_SHIFT  = 1;
    localparam int unsigned DEF_REFRAC      = 2;
    localparam int unsigned DEF_CW          = 8;

    // Widest result sat_add supports; callers narrow the return value to w bits.
    localparam int unsigned SAT_MAX_W = 32;

    // a + b without wrap: anything above 2^w-1 is clipped to 2^w-1.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int unsigned          w
    );
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
        return (sum > lim) ? lim[SAT_MAX_W-1:0] : sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/lif_chain_net_cell.sv
// One leaky integrate-and-fire neuron: membrane state, refractory counter, spike flag.
//   clk, reset   : clock, synchronous active-high reset
//   i_en         : step enable, 0 holds every register
//   i_threshold  : firing threshold
//   i_cur        : input current for this step (W+1 bits, already weighted)
//   o_state      : registered membrane state
//   o_spike      : registered spike flag
//   o_fire_c     : combinational, this edge will set the spike flag
module lif_cell
    import lif_pkg::*;
#(
    parameter int unsigned W          = DEF_W,
    parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int unsigned REFRAC     = DEF_REFRAC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [W-1:0] i_threshold,
    input  logic [W:0]   i_cur,
    output logic [W-1:0] o_state,
    output logic         o_spike,
    output logic         o_fire_c
);

    localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic [RW-1:0] r_refrac;
    logic [W-1:0]  r_state;
    logic          r_spike;

    logic [W-1:0]  w_leak;
    logic [W-1:0]  w_decayed;
    logic [W-1:0]  w_integrated;
    logic          w_refractory;
    logic          w_over;

    // Leak never exceeds the state, so the subtraction cannot underflow.
    assign w_leak       = r_state >> LEAK_SHIFT;
    assign w_decayed    = r_state - w_leak;
    assign w_integrated = W'(sat_add(SAT_MAX_W'(w_decayed), SAT_MAX_W'(i_cur), W));
    assign w_refractory = (r_refrac != '0);
    assign w_over       = (r_state >= i_threshold);
    assign o_fire_c     = i_en && !w_refractory && w_over;

    // Neuron update: refractory hold, then fire, then leak-and-integrate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= '0;
            r_spike  <= 1'b0;
            r_refrac <= '0;
        end else if (i_en) begin
            if (w_refractory) begin
                r_state  <= '0;
                r_spike  <= 1'b0;
                r_refrac <= r_refrac - RW'(1);
            end else if (w_over) begin
                r_state  <= '0;
                r_spike  <= 1'b1;
                r_refrac <= RW'(REFRAC);
            end else begin
                r_state  <= w_integrated;
                r_spike  <= 1'b0;
            end
        end
    end

    assign o_state = r_state;
    assign o_spike = r_spike;

endmodule

// File: rtl/lif_chain_net.sv
// Chain of leaky integrate-and-fire neurons with inter-stage synaptic weighting
// and a saturating spike counter on the last neuron.
//   clk, reset   : clock, synchronous active-high reset (clears all state)
//   en           : step enable, 0 holds every neuron register
//   threshold    : shared firing threshold
//   weight       : shared synaptic weight from neuron i-1 to neuron i
//   ext_current  : per-neuron external current, neuron i at [i*W +: W]
//   cnt_clr      : clear spike counter (honoured regardless of en)
//   state_out    : membrane states, same packing as ext_current
//   spike        : registered spike flags
//   spike_count  : saturating count of last-neuron spikes
module lif_chain_net
    import lif_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int unsigned W           = DEF_W,
    parameter int unsigned LEAK_SHIFT  = DEF_LEAK_SHIFT,
    parameter int unsigned REFRAC      = DEF_REFRAC,
    parameter int unsigned CW          = DEF_CW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [W-1:0]             threshold,
    input  logic [W-1:0]             weight,
    input  logic [NUM_NEURONS*W-1:0] ext_current,
    input  logic                     cnt_clr,
    output logic [NUM_NEURONS*W-1:0] state_out,
    output logic [NUM_NEURONS-1:0]   spike,
    output logic [CW-1:0]            spike_count
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [NUM_NEURONS-1:0] w_fire;
    logic [CW-1:0]          r_spike_count;

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_cell
        logic [W:0] w_cur;

        // Upstream spike is the registered flag, giving one step of synaptic delay.
        if (g == 0) begin : g_first
            assign w_cur = {1'b0, ext_current[0 +: W]};
        end else begin : g_rest
            assign w_cur = {1'b0, ext_current[g*W +: W]} + (spike[g-1] ? {1'b0, weight} : '0);
        end

        lif_cell #(
            .W          (W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRAC     (REFRAC)
        ) u_cell (
            .clk         (clk),
            .reset       (reset),
            .i_en        (en),
            .i_threshold (threshold),
            .i_cur       (w_cur),
            .o_state     (state_out[g*W +: W]),
            .o_spike     (spike[g]),
            .o_fire_c    (w_fire[g])
        );
    end

    // Counts on the same edge the last spike flag rises; clear beats increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_spike_count <= '0;
        end else if (cnt_clr) begin
            r_spike_count <= '0;
        end else if (w_fire[NUM_NEURONS-1] && (r_spike_count != CNT_MAX)) begin
            r_spike_count <= r_spike_count + CW'(1);
        end
    end

    assign spike_count = r_spike_count;

endmodule

// File: tb/tb_lif_chain_net.sv
// Self-checking bench for lif_chain_net: directed trace tables, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_lif_chain_net;

    localparam int N      = 3;
    localparam int W      = 8;
    localparam int LS     = 1;
    localparam int REFRAC = 2;
    localparam int SMAX   = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             cnt_clr;
    logic [W-1:0]     threshold;
    logic [W-1:0]     weight;
    logic [N*W-1:0]   ext_current;
    logic [N*W-1:0]   state_out;
    logic [N-1:0]     spike;
    logic [7:0]       spike_count;
    logic [N*W-1:0]   state_out2;
    logic [N-1:0]     spike2;
    logic [1:0]       spike_count2;

    always #5 clk = ~clk;

    lif_chain_net #(.NUM_NEURONS(N), .W(W), .LEAK_SHIFT(LS), .REFRAC(REFRAC), .CW(8)) u_dut (
        .clk(clk), .reset(reset), .en(en), .threshold(threshold), .weight(weight),
        .ext_current(ext_current), .cnt_clr(cnt_clr),
        .state_out(state_out), .spike(spike), .spike_count(spike_count)
    );

    lif_chain_net #(.NUM_NEURONS(N), .W(W), .LEAK_SHIFT(LS), .REFRAC(REFRAC), .CW(2)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .threshold(threshold), .weight(weight),
        .ext_current(ext_current), .cnt_clr(cnt_clr),
        .state_out(state_out2), .spike(spike2), .spike_count(spike_count2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the chain, plain integers.
    int m_state [N];
    int m_spike [N];
    int m_ref   [N];
    int m_cnt8;
    int m_cnt2;

    typedef struct {
        bit rst;
        int thr;
        int ext0;
        int exp_s0;
        int exp_sp0;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit rst, int thr, int ext0, int s0, int sp0);
        vec_t v;
        v.rst = rst; v.thr = thr; v.ext0 = ext0; v.exp_s0 = s0; v.exp_sp0 = sp0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_state_vec();
        int v = 0;
        for (int i = 0; i < N; i++) v = v | (m_state[i] << (i * W));
        return v;
    endfunction

    function automatic int exp_spike_vec();
        int v = 0;
        for (int i = 0; i < N; i++) v = v | (m_spike[i] << i);
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        int ns [N];
        int nsp[N];
        int nr [N];
        int cur;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_state[i] = 0; m_spike[i] = 0; m_ref[i] = 0;
            end
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                ns[i] = m_state[i]; nsp[i] = m_spike[i]; nr[i] = m_ref[i];
            end
            if (en) begin
                for (int i = 0; i < N; i++) begin
                    cur = int'(ext_current[i*W +: W]);
                    if (i > 0) begin
                        if (m_spike[i-1] == 1) cur = cur + int'(weight);
                    end
                    if (m_ref[i] > 0) begin
                        ns[i] = 0; nsp[i] = 0; nr[i] = m_ref[i] - 1;
                    end else if (m_state[i] >= int'(threshold)) begin
                        ns[i] = 0; nsp[i] = 1; nr[i] = REFRAC;
                    end else begin
                        nsp[i] = 0;
                        ns[i]  = m_state[i] - m_state[i] / (1 << LS) + cur;
                        if (ns[i] > SMAX) ns[i] = SMAX;
                    end
                end
            end
            if (cnt_clr) begin
                m_cnt8 = 0;
                m_cnt2 = 0;
            end else if (en && nsp[N-1] == 1) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
            for (int i = 0; i < N; i++) begin
                m_state[i] = ns[i]; m_spike[i] = nsp[i]; m_ref[i] = nr[i];
            end
        end
    endtask

    task automatic check_all();
        chk("state_out",    32'(state_out),    exp_state_vec());
        chk("spike",        32'(spike),        exp_spike_vec());
        chk("spike_count",  32'(spike_count),  m_cnt8);
        chk("state_out_c2", 32'(state_out2),   exp_state_vec());
        chk("spike_c2",     32'(spike2),       exp_spike_vec());
        chk("spike_count2", 32'(spike_count2), m_cnt2);
    endtask

    // One clock edge: update model, then sample DUT 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        en          = 1'b1;
        cnt_clr     = 1'b0;
        threshold   = 8'd100;
        weight      = 8'd0;
        ext_current = '0;
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0; m_spike[i] = 0; m_ref[i] = 0;
        end
        m_cnt8 = 0;
        m_cnt2 = 0;

        // Directed traces for neuron 0: pure integration, then periodic firing.
        tv.push_back(mk(1, 100, 40,   0, 0));
        tv.push_back(mk(0, 100, 40,  40, 0));
        tv.push_back(mk(0, 100, 40,  60, 0));
        tv.push_back(mk(0, 100, 40,  70, 0));
        tv.push_back(mk(0, 100, 40,  75, 0));
        tv.push_back(mk(0, 100, 40,  78, 0));
        tv.push_back(mk(0, 100, 40,  79, 0));
        tv.push_back(mk(0, 100, 40,  80, 0));
        tv.push_back(mk(0, 100, 40,  80, 0));
        tv.push_back(mk(0, 100, 40,  80, 0));
        tv.push_back(mk(1, 100, 60,   0, 0));
        tv.push_back(mk(0, 100, 60,  60, 0));
        tv.push_back(mk(0, 100, 60,  90, 0));
        tv.push_back(mk(0, 100, 60, 105, 0));
        tv.push_back(mk(0, 100, 60,   0, 1));
        tv.push_back(mk(0, 100, 60,   0, 0));
        tv.push_back(mk(0, 100, 60,   0, 0));
        tv.push_back(mk(0, 100, 60,  60, 0));
        tv.push_back(mk(0, 100, 60,  90, 0));
        tv.push_back(mk(0, 100, 60, 105, 0));
        tv.push_back(mk(0, 100, 60,   0, 1));

        foreach (tv[k]) begin
            reset       = tv[k].rst;
            threshold   = 8'(tv[k].thr);
            weight      = 8'd0;
            ext_current = {16'd0, 8'(tv[k].ext0)};
            step();
            chk("tbl_state0", 32'(state_out[7:0]), tv[k].exp_s0);
            chk("tbl_spike0", 32'(spike[0]),       tv[k].exp_sp0);
        end
        reset = 1'b0;

        // Spike propagation down the chain with one-step synaptic delay.
        threshold   = 8'd100;
        weight      = 8'd255;
        ext_current = {8'd0, 8'd0, 8'd255};
        do_reset();
        step(); chk("prop_state0_e1", 32'(state_out[7:0]),   255);
        step(); chk("prop_spike0_e2", 32'(spike[0]),         1);
        step(); chk("prop_state1_e3", 32'(state_out[15:8]),  255);
        step(); chk("prop_spike1_e4", 32'(spike[1]),         1);
        step(); chk("prop_state2_e5", 32'(state_out[23:16]), 255);
        step(); chk("prop_spike2_e6", 32'(spike[2]),         1);
                chk("prop_count_e6",  32'(spike_count),      1);

        // Saturation of the integrated sum, then firing at threshold 255.
        threshold   = 8'd255;
        weight      = 8'd0;
        ext_current = {16'd0, 8'd200};
        do_reset();
        step(); chk("sat_state0_pre", 32'(state_out[7:0]), 200);
        ext_current = {16'd0, 8'd255};
        step(); chk("sat_state0_clip", 32'(state_out[7:0]), 255);
                chk("sat_spike0_clip", 32'(spike[0]),       0);
        step(); chk("sat_spike0_fire", 32'(spike[0]),       1);

        // Enable freeze mid-refractory, resume, then reset during refractory.
        threshold   = 8'd100;
        ext_current = {16'd0, 8'd60};
        do_reset();
        repeat (5) step();
        en = 1'b0;
        repeat (5) step();
        chk("freeze_state0", 32'(state_out[7:0]), 0);
        en = 1'b1;
        repeat (5) step();
        chk("resume_spike0", 32'(spike[0]), 1);
        reset = 1'b1;
        step(); chk("rst_refrac_spike", 32'(spike),     0);
                chk("rst_refrac_state", 32'(state_out), 0);
        reset = 1'b0;
        step(); chk("rst_release_state0", 32'(state_out[7:0]), 60);
                chk("rst_release_spike0", 32'(spike[0]),       0);

        // Threshold 0: firing every third edge; 2-bit counter saturates; clear wins.
        threshold   = 8'd0;
        ext_current = '0;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1)  chk("cnt2_first",  32'(spike_count2), 1);
            if (k == 4)  chk("cnt2_second", 32'(spike_count2), 2);
            if (k == 7)  chk("cnt2_third",  32'(spike_count2), 3);
            if (k == 10) begin
                chk("cnt2_sat",    32'(spike_count2), 3);
                chk("cnt8_fourth", 32'(spike_count),  4);
            end
        end
        cnt_clr = 1'b1;
        step(); chk("clr_spike2", 32'(spike[2]),     1);
                chk("clr_cnt2",   32'(spike_count2), 0);
                chk("clr_cnt8",   32'(spike_count),  0);
        cnt_clr = 1'b0;

        // Randomized stimulus against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            en        = ($urandom_range(0, 7) != 0);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            threshold = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(20, 255));
            weight    = 8'($urandom_range(0, 255));
            for (int i = 0; i < N; i++) ext_current[i*W +: W] = 8'($urandom_range(0, 90));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
